// File: rtl/max7219_chain_driver.sv
// max7219_chain_driver: bit-banged init/refresh/intensity driver for a daisy-chain of MAX7219 devices
// Ports: i_clock, i_reset (sync, active-high); i_update pulse captures i_data/i_decode into the shadow;
//        i_brightness is the live intensity value; o_busy/o_done report sequence status;
//        o_sck/o_din/o_load drive CLK/DIN/LOAD of the chain (device 0 nearest o_din).
// Optional: define MAX7219_SHUTDOWN_EN to add i_blank, which rewrites the shutdown register from IDLE.
module max7219_chain_driver #(
    parameter int N_DEV   = 1,
    parameter int N_DIG   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_update,
    input  logic                     i_decode,
    input  logic [3:0]               i_brightness,
    input  logic [N_DEV*N_DIG*8-1:0] i_data,
`ifdef MAX7219_SHUTDOWN_EN
    input  logic                     i_blank,
`endif
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_sck,
    output logic                     o_din,
    output logic                     o_load
);
    localparam int NB = 16 * N_DEV;
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(NB + 1);
    localparam int GW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int AW = N_DEV * N_DIG * 8;

    typedef enum logic [2:0] {
        S_INIT_SHDN, S_INIT_TEST, S_INIT_SCAN, S_SEND_DEC,
        S_SEND_INT, S_SEND_DIG, S_SEND_SHDN, S_IDLE
    } state_t;

    state_t          r_state, w_state_nx;
    logic            r_run, r_pending, r_sdec, r_adec, r_solo;
    logic [AW-1:0]   r_shadow, r_active;
    logic [3:0]      r_last;
    logic [DW-1:0]   r_div;
    logic [BW-1:0]   r_bit;
    logic [GW-1:0]   r_dig;
    logic            w_idle, w_latch, w_last_div, w_fend, w_refresh;
    logic            w_start_int, w_start_shdn, w_shdn_bit, w_din;
    logic [15:0]     w_cmd;
    logic [NB-1:0]   w_frame;

    // r_run is low for the cycle after reset so the pins sit at their idle levels before init starts
    assign w_idle      = r_state == S_IDLE;
    assign w_latch     = r_bit == BW'(NB);
    assign w_last_div  = r_div == DW'(2 * CLK_DIV - 1);
    assign w_fend      = r_run && w_latch && w_last_div;
    assign w_refresh   = r_pending || i_update;
    assign w_start_int = i_brightness != r_last;

`ifdef MAX7219_SHUTDOWN_EN
    logic r_last_blank;
    assign w_start_shdn = i_blank != r_last_blank;
    assign w_shdn_bit   = ~r_last_blank;
    always_ff @(posedge i_clock)
        if (i_reset)
            r_last_blank <= 1'b0;
        else if (r_run && w_idle && !w_refresh && w_start_shdn)
            r_last_blank <= i_blank;
`else
    assign w_start_shdn = 1'b0;
    assign w_shdn_bit   = 1'b1;
`endif

    always_ff @(posedge i_clock)
        r_state <= i_reset ? S_INIT_SHDN : w_state_nx;

    always_comb begin
        w_state_nx = r_state;
        if (r_run && w_idle)
            w_state_nx = w_refresh ? S_SEND_DEC : w_start_shdn ? S_SEND_SHDN :
                         w_start_int ? S_SEND_INT : S_IDLE;
        else if (w_fend)
            case (r_state)
                S_INIT_SHDN: w_state_nx = S_INIT_TEST;
                S_INIT_TEST: w_state_nx = S_INIT_SCAN;
                S_INIT_SCAN: w_state_nx = S_SEND_DEC;
                S_SEND_DEC:  w_state_nx = S_SEND_INT;
                S_SEND_INT:  w_state_nx = r_solo ? S_IDLE : S_SEND_DIG;
                S_SEND_DIG:  w_state_nx = (r_dig == GW'(N_DIG - 1)) ? S_IDLE : S_SEND_DIG;
                default:     w_state_nx = S_IDLE;
            endcase
    end

    // Frame image: device d owns bits [d*16 +: 16], so the MSB end leaves first and reaches the far device
    always_comb begin
        w_cmd = (r_state == S_INIT_SHDN) ? 16'h0C01 :
                (r_state == S_INIT_TEST) ? 16'h0F00 :
                (r_state == S_INIT_SCAN) ? {8'h0B, 8'(N_DIG - 1)} :
                (r_state == S_SEND_DEC)  ? {8'h09, {8{r_adec}}} :
                (r_state == S_SEND_INT)  ? {8'h0A, 4'h0, r_last} :
                (r_state == S_SEND_SHDN) ? {8'h0C, 7'h00, w_shdn_bit} : 16'h0000;
        w_frame = '0;
        for (int d = 0; d < N_DEV; d++)
            w_frame[d*16 +: 16] = (r_state == S_SEND_DIG) ?
                {8'(r_dig) + 8'd1, r_active[(d*N_DIG + int'(r_dig))*8 +: 8]} : w_cmd;
        w_din = 1'b0;
        for (int i = 0; i < NB; i++)
            if (r_bit == BW'(i))
                w_din = w_frame[NB-1-i];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_run     <= 1'b0;
            r_div     <= '0;
            r_bit     <= '0;
            r_dig     <= '0;
            r_pending <= 1'b0;
            r_shadow  <= '0;
            r_sdec    <= 1'b0;
            r_active  <= '0;
            r_adec    <= 1'b0;
            r_solo    <= 1'b0;
            r_last    <= '0;
        end else begin
            r_run <= 1'b1;
            if (r_run && !w_idle) begin
                r_div <= w_last_div ? '0 : r_div + 1'b1;
                if (w_last_div)
                    r_bit <= w_latch ? '0 : r_bit + 1'b1;
            end
            if (w_fend)
                r_dig <= (r_state == S_SEND_DIG && r_dig != GW'(N_DIG - 1)) ? r_dig + 1'b1 : '0;
            // Intensity data is taken from r_last, which is stable by the time its bits are shifted
            if (r_run && r_state == S_SEND_INT && r_div == '0 && r_bit == '0)
                r_last <= i_brightness;
            if (i_update) begin
                r_shadow <= i_data;
                r_sdec   <= i_decode;
            end
            if (r_run && w_idle) begin
                r_pending <= 1'b0;
                r_solo    <= !w_refresh;
                if (w_refresh) begin
                    r_active <= i_update ? i_data : r_shadow;
                    r_adec   <= i_update ? i_decode : r_sdec;
                end
            end else if (i_update)
                r_pending <= 1'b1;
        end
    end

    assign o_load = !r_run || w_idle || w_latch;
    assign o_sck  = !w_latch && r_div >= DW'(CLK_DIV);
    assign o_din  = w_din && !o_load;
    assign o_busy = r_run && (!w_idle || r_pending);
    assign o_done = w_fend && w_state_nx == S_IDLE;
endmodule

// File: doc/max7219_chain_driver.md
# max7219_chain_driver

Parametrised MAX7219 driver: owns SPI-style bit-banging (`sck`/`din`/`load`) for a daisy-chain of `N_DEV` MAX7219 devices with `N_DIG` digits each. It runs the power-up init sequence, refreshes all digit registers on an `update` pulse, and pushes brightness changes without a full refresh. It sits between the application `display` wrapper and the board pins, replacing the single-device, fixed-8-digit sender.

## Interface
- `N_DEV`, 1: cascaded devices, 1..8.
- `N_DIG`, 8: digits per device, 1..8; scan-limit register = `N_DIG-1`.
- `CLK_DIV`, 4: `clock` cycles per `sck` half-period, ≥1.
- `clock` in 1: single system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `update` in 1: one-cycle pulse; captures `data`/`decode` into the shadow register and requests a refresh.
- `decode` in 1: 1 = code-B on all digits (decode reg 0xFF), 0 = raw segments (0x00).
- `brightness` in 4: intensity register value, sampled continuously.
- `data` in `N_DEV*N_DIG*8`: byte `[(d*N_DIG+k)*8 +: 8]` → device d, digit register k+1. Device 0 is wired to `din`.
- `busy` out 1: high while any frame is in progress or queued.
- `done` out 1: one-cycle pulse when a sequence (init, refresh or intensity-only) completes.
- `sck`, `din`, `load` out 1: MAX7219 CLK, DIN, LOAD/CS.

## Operation
- Frame = one register write to every device. `load` is low during the shift. The frame shifts `N_DEV*16` bits MSB first: {addr[7:0], data[7:0]} of device `N_DEV-1` first, device 0 last. Every device receives the same address.
- FSM: `INIT_SHDN`(0x0C←0x01) → `INIT_TEST`(0x0F←0x00) → `INIT_SCAN`(0x0B←N_DIG-1) → `SEND_DEC` → `SEND_INT` → `SEND_DIG`(k=0..N_DIG-1, addr k+1) → `IDLE`.
- Reset release enters `INIT_SHDN`. The init sequence uses the reset value of the shadow register (all zero, decode=0) and the live `brightness`.
- `IDLE` with refresh pending: copy shadow → active, clear pending, run `SEND_DEC` → `SEND_INT` → `SEND_DIG` → `IDLE`.
- `IDLE` with no refresh pending and `brightness != last_sent`: run a single `SEND_INT` frame → `IDLE`. A refresh takes priority, because its `SEND_INT` also clears the mismatch.
- `last_sent` is the `brightness` value sampled on the first cycle of each `SEND_INT` frame.
- `update` while busy: the shadow is overwritten (last pulse wins) and pending is set. This gives a one-deep queue; the refresh starts on the cycle after the current sequence's `done`.
- Frames only read the active copy. Changing `data` mid-sequence never corrupts the sequence in flight.
- `busy` = (state != `IDLE`) | pending.

## Timing
- Reset values: `sck`=0, `din`=0, `load`=1, `busy`=0, `done`=0, shadow/active/pending/last_sent=0, state=`INIT_SHDN`. `busy`=1 from the first cycle after `reset` deasserts.
- Bit phase: 2·CLK_DIV cycles. `din` is stable for the whole phase; `sck`=0 for the first CLK_DIV cycles and 1 for the second CLK_DIV cycles.
- Latch phase (after the last bit): `sck`=0, `load`=1 for 2·CLK_DIV cycles. `load` rises on the same cycle `sck` falls after the final bit.
- Frame length F = 2·CLK_DIV·(16·N_DEV + 1) cycles. Frames are back-to-back, with no extra gaps.
- `done` is asserted on the last cycle of the final latch phase of a sequence. `IDLE` is entered the next cycle.
- `update` → first `load` fall: 1 cycle if idle.
- `reset` mid-frame: outputs return to reset values on the next edge, and init restarts. A partial frame is never latched because `load` stays high.

## Configuration
- `MAX7219_SHUTDOWN_EN` defined: adds input `blank` (1 bit).
  - In `IDLE`, when `blank != last_blank`, send one frame 0x0C←{7'b0,~blank} and update `last_blank`.
  - Priority order: refresh > shutdown > intensity.
  - `last_blank` resets to 0.
- Not defined: no `blank` port; shutdown register is written only during init.

## Test plan
- Params N_DEV=2, N_DIG=4, CLK_DIV=2 (F=132):
  - Release reset → 9 frames, `busy` high for 1188 cycles, then `done` pulses once.
  - Captured third frame is 0x0B03_0B03.
- Idle, `data`=0x…, device1 digit1 = 0xA5, device0 digit1 = 0x3C, `decode`=0, pulse `update` → `load` falls next cycle; 6 frames (792 cycles). Frame 3 = 0x01A5_013C; frame 1 = 0x0900_0900.
- Idle, `brightness` 7→12 with no update → exactly one frame 0x0A0C_0A0C, `done` after 132 cycles. Holding 12 produces no further frames.
- Two `update` pulses during init carrying values X then Y → after init `done`, exactly one refresh runs, carrying Y. `busy` stays continuously high.
- `reset` asserted at bit 10 of a refresh frame → `load`=1, `sck`=0 next cycle. After release, init restarts with frame 0x0C01_0C01.
- With `MAX7219_SHUTDOWN_EN`, `blank` 0→1 in idle → single frame 0x0C00_0C00.
